// File: rtl/stream_unpack_128to32.sv
// Serialises 128-bit beats into 32-bit words, emitting only the lanes enabled in LANE_MASK.
// Optional: define STREAM_UNPACK_BSWAP_EN to byte-reverse each emitted word.
module stream_unpack_128to32 #(
  parameter logic [3:0] LANE_MASK = 4'b1111,
  parameter int         COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               si_valid,
  output logic               si_rdy,
  input  logic [127:0]       si_data,
  output logic               so_valid,
  input  logic               so_rdy,
  output logic [31:0]        so_data,
  output logic               so_last,
  output logic [COUNT_W-1:0] word_count
);

  if (LANE_MASK == 4'b0000) begin : g_bad_mask
    $error("stream_unpack_128to32: LANE_MASK must be nonzero");
  end

  function automatic int first_lane();
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) if (LANE_MASK[i]) r = i;
    return r;
  endfunction

  function automatic int last_lane();
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (LANE_MASK[i]) r = i;
    return r;
  endfunction

  // Lanes with no enabled successor wrap to FIRST; only reachable for LAST.
  function automatic int next_lane(input int cur);
    int r;
    r = first_lane();
    for (int i = 3; i > cur; i--) if (LANE_MASK[i]) r = i;
    return r;
  endfunction

  localparam logic [1:0] FIRST  = 2'(first_lane());
  localparam logic [1:0] LAST   = 2'(last_lane());
  localparam logic [1:0] NEXT_0 = 2'(next_lane(0));
  localparam logic [1:0] NEXT_1 = 2'(next_lane(1));
  localparam logic [1:0] NEXT_2 = 2'(next_lane(2));

  logic [127:0] data_q;
  logic         full;
  logic [1:0]   idx;
  logic [1:0]   idx_next;
  logic [31:0]  lane;
  logic         at_last;
  logic         in_xfer;
  logic         out_xfer;

  always_comb begin
    idx_next = FIRST;
    case (idx)
      2'd0:    idx_next = NEXT_0;
      2'd1:    idx_next = NEXT_1;
      2'd2:    idx_next = NEXT_2;
      default: idx_next = FIRST;
    endcase
  end

  assign at_last  = (idx == LAST);
  assign so_valid = full;
  assign so_last  = full && at_last;
  assign out_xfer = full && so_rdy;
  assign si_rdy   = ~full || (out_xfer && at_last);
  assign in_xfer  = si_valid && si_rdy;
  assign lane     = data_q[{idx, 5'd0} +: 32];

`ifdef STREAM_UNPACK_BSWAP_EN
  assign so_data = {lane[7:0], lane[15:8], lane[23:16], lane[31:24]};
`else
  assign so_data = lane;
`endif

  // A new beat may land on the same edge the last lane leaves, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      full       <= 1'b0;
      idx        <= FIRST;
      word_count <= '0;
    end else begin
      if (out_xfer) word_count <= word_count + COUNT_W'(1);
      if (in_xfer) begin
        data_q <= si_data;
        full   <= 1'b1;
        idx    <= FIRST;
      end else if (out_xfer) begin
        if (at_last) begin
          full <= 1'b0;
          idx  <= FIRST;
        end else begin
          idx <= idx_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_unpack_128to32.sv
// Directed bench for stream_unpack_128to32: full, sparse and single-lane masks plus a narrow counter.
// Honours STREAM_UNPACK_BSWAP_EN when computing expected words.
module tb_stream_unpack_128to32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef STREAM_UNPACK_BSWAP_EN
  localparam logic [31:0] EXP_DEADBEEF = 32'hefbeadde;
`else
  localparam logic [31:0] EXP_DEADBEEF = 32'hdeadbeef;
`endif

  // full mask, 32-bit counter
  logic a_si_valid, a_si_rdy, a_so_valid, a_so_rdy, a_so_last;
  logic [127:0] a_si_data;
  logic [31:0]  a_so_data, a_word_count;
  // mask 0110
  logic b_si_valid, b_si_rdy, b_so_valid, b_so_rdy, b_so_last;
  logic [127:0] b_si_data;
  logic [31:0]  b_so_data, b_word_count;
  // full mask, 4-bit counter
  logic c_si_valid, c_si_rdy, c_so_valid, c_so_rdy, c_so_last;
  logic [127:0] c_si_data;
  logic [31:0]  c_so_data;
  logic [3:0]   c_word_count;
  // single lane 0100
  logic d_si_valid, d_si_rdy, d_so_valid, d_so_rdy, d_so_last;
  logic [127:0] d_si_data;
  logic [31:0]  d_so_data, d_word_count;

  stream_unpack_128to32 #(.LANE_MASK(4'b1111), .COUNT_W(32)) u_a (
    .clk(clk), .rst(rst), .si_valid(a_si_valid), .si_rdy(a_si_rdy), .si_data(a_si_data),
    .so_valid(a_so_valid), .so_rdy(a_so_rdy), .so_data(a_so_data), .so_last(a_so_last),
    .word_count(a_word_count));
  stream_unpack_128to32 #(.LANE_MASK(4'b0110), .COUNT_W(32)) u_b (
    .clk(clk), .rst(rst), .si_valid(b_si_valid), .si_rdy(b_si_rdy), .si_data(b_si_data),
    .so_valid(b_so_valid), .so_rdy(b_so_rdy), .so_data(b_so_data), .so_last(b_so_last),
    .word_count(b_word_count));
  stream_unpack_128to32 #(.LANE_MASK(4'b1111), .COUNT_W(4)) u_c (
    .clk(clk), .rst(rst), .si_valid(c_si_valid), .si_rdy(c_si_rdy), .si_data(c_si_data),
    .so_valid(c_so_valid), .so_rdy(c_so_rdy), .so_data(c_so_data), .so_last(c_so_last),
    .word_count(c_word_count));
  stream_unpack_128to32 #(.LANE_MASK(4'b0100), .COUNT_W(32)) u_d (
    .clk(clk), .rst(rst), .si_valid(d_si_valid), .si_rdy(d_si_rdy), .si_data(d_si_data),
    .so_valid(d_so_valid), .so_rdy(d_so_rdy), .so_data(d_so_data), .so_last(d_so_last),
    .word_count(d_word_count));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ew(input logic [31:0] x);
`ifdef STREAM_UNPACK_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  function automatic logic [127:0] b2b_beat(input int k);
    logic [31:0] base;
    base = 32'hc0de0000 + 32'(k * 16);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  function automatic logic [127:0] single_beat(input int k);
    return {32'h33000000 + 32'(k), 32'h22000000 + 32'(k), 32'h11000000 + 32'(k), 32'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_si_valid = 0; a_so_rdy = 1; b_si_valid = 0; b_so_rdy = 1;
    c_si_valid = 0; c_so_rdy = 1; d_si_valid = 0; d_so_rdy = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] beat;
    int k;
    logic hs;
    a_si_data = '0; b_si_data = '0; c_si_data = '0; d_si_data = '0;

    // reset state
    do_reset();
    check("rst_valid", a_so_valid, 0);
    check("rst_last", a_so_last, 0);
    check("rst_count", a_word_count, 0);
    check("rst_si_rdy", a_si_rdy, 1);

    // basic single beat
    beat = 128'h42424242_deadbeef_00000005_00000005;
    a_si_data = beat; a_si_valid = 1; a_so_rdy = 1;
    tick();
    a_si_valid = 0; #1;
    check("basic_w0", a_so_data, ew(32'h00000005)); check("basic_l0", a_so_last, 0);
    check("basic_v0", a_so_valid, 1);
    tick(); #1;
    check("basic_w1", a_so_data, ew(32'h00000005)); check("basic_l1", a_so_last, 0);
    tick(); #1;
    check("basic_w2", a_so_data, EXP_DEADBEEF); check("basic_l2", a_so_last, 0);
    tick(); #1;
    check("basic_w3", a_so_data, ew(32'h42424242)); check("basic_l3", a_so_last, 1);
    check("basic_rdy3", a_si_rdy, 1);
    tick(); #1;
    check("basic_empty", a_so_valid, 0);
    check("basic_count", a_word_count, 4);

    // back-to-back beats
    do_reset();
    k = 0;
    for (int c = 0; c <= 13; c++) begin
      a_si_valid = (k < 3);
      a_si_data  = b2b_beat(k);
      #1;
      hs = a_si_valid && a_si_rdy;
      if (c <= 12) check("b2b_si_rdy", a_si_rdy, (c % 4) == 0);
      if (c >= 1 && c <= 12) begin
        check("b2b_valid", a_so_valid, 1);
        check("b2b_data", a_so_data,
              ew(32'hc0de0000 + 32'(((c - 1) / 4) * 16 + (c - 1) % 4)));
        check("b2b_last", a_so_last, (c % 4) == 0);
      end
      if (c == 13) begin
        check("b2b_empty", a_so_valid, 0);
        check("b2b_count", a_word_count, 12);
      end
      tick();
      if (hs) k++;
    end
    a_si_valid = 0;

    // backpressure on lane 1
    do_reset();
    beat = 128'h44444444_33333333_22222222_11111111;
    a_si_data = beat; a_si_valid = 1;
    tick();
    a_si_valid = 0; #1;
    check("bp_w0", a_so_data, ew(32'h11111111));
    tick(); #1;
    a_so_rdy = 0; #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", a_so_valid, 1);
      check("bp_hold_data", a_so_data, ew(32'h22222222));
      check("bp_hold_si_rdy", a_si_rdy, 0);
      tick();
    end
    a_so_rdy = 1; #1;
    check("bp_w1", a_so_data, ew(32'h22222222));
    tick(); #1;
    check("bp_w2", a_so_data, ew(32'h33333333));
    tick(); #1;
    check("bp_w3", a_so_data, ew(32'h44444444)); check("bp_l3", a_so_last, 1);
    tick(); #1;
    check("bp_count", a_word_count, 4);

    // sparse mask 0110
    do_reset();
    b_si_data = 128'h44444444_33333333_22222222_11111111; b_si_valid = 1;
    tick();
    b_si_valid = 0; #1;
    check("m6_w0", b_so_data, ew(32'h22222222)); check("m6_l0", b_so_last, 0);
    tick(); #1;
    check("m6_w1", b_so_data, ew(32'h33333333)); check("m6_l1", b_so_last, 1);
    check("m6_rdy", b_si_rdy, 1);
    tick(); #1;
    check("m6_empty", b_so_valid, 0);
    check("m6_count", b_word_count, 2);

    // reset mid-beat
    do_reset();
    a_si_data = 128'h44444444_33333333_22222222_11111111; a_si_valid = 1;
    tick();
    a_si_valid = 0; #1;
    tick(); #1;
    check("mid_w1", a_so_data, ew(32'h22222222));
    rst = 1;
    tick();
    rst = 0; #1;
    check("mid_valid", a_so_valid, 0);
    check("mid_last", a_so_last, 0);
    check("mid_count", a_word_count, 0);
    tick(); #1;
    check("mid_stay_empty", a_so_valid, 0);
    a_si_data = 128'h88888888_77777777_66666666_55555555; a_si_valid = 1;
    tick();
    a_si_valid = 0; #1;
    check("mid_new_first", a_so_data, ew(32'h55555555));
    check("mid_new_count", a_word_count, 0);

    // 4-bit counter wrap after 20 words
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      c_si_valid = (c <= 16);
      c_si_data  = {4{32'(c)}};
      #1;
      if (c == 16) check("wrap_pre", c_word_count, 15);
      tick();
    end
    c_si_valid = 0; #1;
    check("wrap_empty", c_so_valid, 0);
    check("wrap_count", c_word_count, 4);

    // single-lane pass-through
    do_reset();
    for (int c = 0; c < 4; c++) begin
      d_si_valid = 1;
      d_si_data  = single_beat(c);
      #1;
      if (c >= 1) begin
        check("one_data", d_so_data, ew(32'h22000000 + 32'(c - 1)));
        check("one_last", d_so_last, 1);
        check("one_si_rdy", d_si_rdy, 1);
      end
      tick();
    end
    d_so_rdy = 0; d_si_data = single_beat(4); #1;
    check("one_stall_rdy", d_si_rdy, 0);
    check("one_stall_data", d_so_data, ew(32'h22000003));
    tick(); #1;
    check("one_hold_data", d_so_data, ew(32'h22000003));
    check("one_count", d_word_count, 3);
    d_si_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
